// File: rtl/if_pkg.sv
// Shared fetch-stage types and constants.
// Used by the prefetching IF stage and by decode when it inserts bubbles.
package if_pkg;

    localparam int IF_ADDR_W = 32;
    localparam int IF_DATA_W = 32;

    // Canonical RV32I nop (addi x0, x0, 0) for decode-side bubble insertion.
    localparam logic [IF_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush, used for the fetch queue and PC tags.
// Ports: clk, rst, flush, push/push_data, pop/pop_data, full, empty, count.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_prefetch.sv
// Prefetching IF stage: PC generation, memory requests, fetch queue to decode.
// Ports: jump_c/jump_addr_i redirect, req_* memory request, rsp_* response, instr_*/pc_o to ID.
module if_prefetch
    import if_pkg::*;
#(
    parameter int                  ADDR_WIDTH      = 32,
    parameter int                  DATA_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR  = '0,
    parameter int                  FQ_DEPTH        = 4,
    parameter int                  MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_c,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    input  logic                  rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] rsp_data_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instruction_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = $clog2(FQ_DEPTH + 1);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [31:0] FQ_D = 32'(FQ_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] pc_tag;
    logic [OW-1:0]         outstanding;
    logic [OW-1:0]         drop_cnt;
    logic [QW-1:0]         q_count;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  q_full;
    logic                  q_empty;
    logic                  credit_ok;
    logic                  out_ok;
    logic                  issue;
    logic                  rsp_push;
    logic                  pop;
    entry_t                q_in;
    entry_t                q_head;

    // Every accepted request owns a queue slot until it is answered,
    // so a response can always be pushed.
    assign credit_ok = (32'(q_count) + 32'(outstanding)) < FQ_D;
    assign out_ok    = outstanding < OW'(MAX_OUTSTANDING);

    assign req_valid_o = !rst && !jump_c
                      && (drop_cnt == '0 || out_ok)
                      && out_ok && !tag_full
                      && credit_ok && !q_full;
    assign req_addr_o  = fetch_pc;
    assign issue       = req_valid_o && req_ready_i;

    // Responses in the jump cycle or owed to a stale stream are discarded.
    assign rsp_push = rsp_valid_i && !tag_empty
                   && !jump_c && (drop_cnt == '0);

    assign q_in.pc    = pc_tag;
    assign q_in.instr = rsp_data_i;

    assign instr_valid_o = !q_empty;
    assign pop           = instr_valid_o && instr_ready_i;
    assign instruction_o = instr_valid_o ? q_head.instr : '0;
    assign pc_o          = instr_valid_o ? q_head.pc : '0;

    // Tag FIFO occupancy doubles as the outstanding-request counter.
    fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ADDR_WIDTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (issue),
        .push_data (fetch_pc),
        .pop       (rsp_valid_i),
        .pop_data  (pc_tag),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (outstanding)
    );

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (EW)
    ) u_fetch_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump_c),
        .push      (rsp_push),
        .push_data (q_in),
        .pop       (pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_VECTOR;
        end else if (jump_c) begin
            fetch_pc <= {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (issue) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        end
    end

    // On redirect, everything still in flight after this edge is stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (jump_c) begin
            if (rsp_valid_i && outstanding != '0)
                drop_cnt <= outstanding - 1'b1;
            else
                drop_cnt <= outstanding;
        end else if (rsp_valid_i && drop_cnt != '0) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: memory model plus in-order scoreboard.
// Drives at negedge, samples 1 ns later, well away from the rising edge.
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_c;
    logic [31:0] jump_addr_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;

    if_prefetch #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .RESET_VECTOR    (32'h100),
        .FQ_DEPTH        (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_c        (jump_c),
        .jump_addr_i   (jump_addr_i),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .req_addr_o    (req_addr_o),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_data_i    (rsp_data_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instruction_o (instruction_o),
        .pc_o          (pc_o)
    );

    always #5 clk = ~clk;

    int          n_chk;
    int          n_pass;
    int          cyc;
    int          lat;
    int          n_iss;
    int          n_pops;
    int          first_iss;
    int          first_vld;
    logic [31:0] first_pop_pc;
    logic [31:0] pred_pc;
    logic [31:0] held;
    logic        mem_rdy;
    logic        dec_rdy;
    logic        jmp_req;
    logic        jmp_arm;
    logic [31:0] jmp_addr;
    logic        was_jump;
    logic        jump_pop;
    logic [31:0] pend_a[$];
    int          pend_d[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'd7) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        jump_c = 1'b0;
        jump_addr_i = '0;
        req_ready_i = 1'b0;
        instr_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_data_i = '0;
        pend_a.delete();
        pend_d.delete();
        exp_q.delete();
        pred_pc = 32'h100;
        first_iss = -1;
        first_vld = -1;
        n_iss = 0;
        n_pops = 0;
        was_jump = 1'b0;
        jmp_req = 1'b0;
        jmp_arm = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        rsp_valid_i = 1'b0;
        rsp_data_i = '0;
        if (pend_a.size() > 0 && pend_d[0] <= cyc) begin
            rsp_valid_i = 1'b1;
            rsp_data_i = mem_f(pend_a[0]);
            void'(pend_a.pop_front());
            void'(pend_d.pop_front());
        end
        req_ready_i = mem_rdy;
        instr_ready_i = dec_rdy;
        jump_c = 1'b0;
        jump_addr_i = jmp_addr;
        if (jmp_req || (jmp_arm && rsp_valid_i && instr_valid_o && dec_rdy)) begin
            jump_c = 1'b1;
            jmp_req = 1'b0;
            jmp_arm = 1'b0;
        end
        #1;
        if (was_jump) chk("flush_empty", instr_valid_o, 1'b0);
        was_jump = jump_c;
        if (instr_valid_o && first_vld < 0) first_vld = cyc;
        if (jump_c) begin
            jump_pop = instr_valid_o && instr_ready_i;
            chk("jump_no_req", req_valid_o, 1'b0);
        end
        if (instr_valid_o && instr_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", pc_o, 32'hxxxx_xxxx);
            end else begin
                chk("pop_pc", pc_o, exp_q[0]);
                chk("pop_instr", instruction_o, mem_f(exp_q[0]));
                void'(exp_q.pop_front());
            end
            if (n_pops == 0) first_pop_pc = pc_o;
            n_pops++;
        end
        if (jump_c) begin
            exp_q.delete();
            pred_pc = {jmp_addr[31:2], 2'b00};
        end
        if (req_valid_o) begin
            chk("req_addr", req_addr_o, pred_pc);
            if (req_ready_i) begin
                exp_q.push_back(pred_pc);
                pend_a.push_back(req_addr_o);
                pend_d.push_back(cyc + lat);
                pred_pc = pred_pc + 32'd4;
                if (first_iss < 0) first_iss = cyc;
                n_iss++;
            end
        end
        cyc++;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        lat = 1;
        mem_rdy = 1'b1;
        dec_rdy = 1'b1;
        jmp_addr = '0;
        jump_pop = 1'b0;
        rst = 1'b1;
        jump_c = 1'b0;
        jump_addr_i = '0;
        req_ready_i = 1'b0;
        instr_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_data_i = '0;
        #2;
        chk("rst_req_valid", req_valid_o, 1'b0);
        chk("rst_instr_valid", instr_valid_o, 1'b0);
        chk("rst_instruction", instruction_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);

        // Streaming with single-cycle memory.
        do_reset();
        repeat (10) step();
        chk("first_latency", 32'(first_vld - first_iss), 32'd2);
        chk("first_pop_pc", first_pop_pc, 32'h100);
        n_pops = 0;
        repeat (10) step();
        chk("throughput", 32'(n_pops), 32'd10);

        // Decode backpressure: credits cap requests at queue depth.
        do_reset();
        dec_rdy = 1'b0;
        repeat (20) step();
        chk("stall_issued", 32'(n_iss), 32'd4);
        chk("stall_req_valid", req_valid_o, 1'b0);
        chk("stall_head_valid", instr_valid_o, 1'b1);
        dec_rdy = 1'b1;
        n_pops = 0;
        repeat (4) step();
        chk("drain_pops", 32'(n_pops), 32'd4);
        repeat (8) step();
        chk("resume_fetch", 32'(n_iss > 4), 32'd1);

        // Memory not ready: address holds.
        mem_rdy = 1'b0;
        held = pred_pc;
        repeat (5) step();
        chk("hold_valid", req_valid_o, 1'b1);
        chk("hold_addr", req_addr_o, held);
        chk("hold_drained", instr_valid_o, 1'b0);
        mem_rdy = 1'b1;
        repeat (6) step();

        // Redirect with two requests in flight.
        do_reset();
        lat = 3;
        repeat (2) step();
        jmp_addr = 32'h2003;
        jmp_req = 1'b1;
        step();
        n_pops = 0;
        repeat (20) if (n_pops == 0) step();
        chk("jump_pop_seen", 32'(n_pops > 0), 32'd1);
        chk("jump_first_pc", first_pop_pc, 32'h2000);

        // Redirect coinciding with a response and a pop.
        do_reset();
        lat = 2;
        repeat (2) step();
        jmp_addr = 32'h3000;
        jmp_arm = 1'b1;
        repeat (10) if (jmp_arm) step();
        chk("arm_fired", jmp_arm, 1'b0);
        chk("jump_pop", jump_pop, 1'b1);
        n_pops = 0;
        repeat (20) if (n_pops == 0) step();
        chk("jump2_first_pc", first_pop_pc, 32'h3000);

        // Asynchronous reset with a full queue.
        do_reset();
        lat = 1;
        dec_rdy = 1'b0;
        repeat (12) step();
        chk("full_head_valid", instr_valid_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_req_valid", req_valid_o, 1'b0);
        chk("async_instr_valid", instr_valid_o, 1'b0);
        do_reset();
        dec_rdy = 1'b1;
        n_pops = 0;
        repeat (20) if (n_pops == 0) step();
        chk("restart_pc", first_pop_pc, 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Parametrised successor to the single-cycle fetch stage. Generates the PC, issues word requests to an instruction memory over a valid/ready request and in-order response interface, and buffers returned {pc, instruction} pairs in a fetch queue.
- Delivers instructions to decode with a valid/ready handshake, so backpressure replaces the old stall input.
- Handles redirects (jump/branch) by flushing the queue and discarding in-flight responses. Sits between the PC/redirect logic and the ID stage.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- DATA_WIDTH, 32, instruction width.
- RESET_VECTOR, 0, PC loaded on reset.
- FQ_DEPTH, 4, fetch-queue entries; power of two, ≥2.
- MAX_OUTSTANDING, 2, maximum accepted but unanswered memory requests; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- jump_c  in  1  redirect request, one cycle.
- jump_addr_i  in  ADDR_WIDTH  redirect target; bits [1:0] ignored, treated as 0.
- req_valid_o  out  1  memory request valid.
- req_ready_i  in  1  memory accepts request.
- req_addr_o  out  ADDR_WIDTH  word-aligned fetch address.
- rsp_valid_i  in  1  memory response valid; in order; always accepted.
- rsp_data_i  in  DATA_WIDTH  fetched instruction.
- instr_valid_o  out  1  queue head valid.
- instr_ready_i  in  1  decode consumes head.
- instruction_o  out  DATA_WIDTH  head instruction.
- pc_o  out  ADDR_WIDTH  head PC.

Behaviour:
- Reset (async assert, sync-released use): fetch_pc=RESET_VECTOR, queue empty, outstanding=0, drop_cnt=0. Hence req_valid_o=0 only while rst high; instr_valid_o=0; instruction_o/pc_o=0.
- Issue rule:
  - req_valid_o = !jump_c && (drop_cnt==0 || outstanding < MAX_OUTSTANDING) && (outstanding < MAX_OUTSTANDING) && (q_count + outstanding < FQ_DEPTH).
  - This is credit-based, so a response always has a free slot and the queue can never overflow.
  - req_addr_o = fetch_pc. On req_valid_o && req_ready_i: fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH) and outstanding++.
- Response:
  - With drop_cnt>0: the response is discarded and drop_cnt--.
  - Otherwise: push {pc_tag, rsp_data_i} into the queue. pc_tag comes from an internal in-order PC FIFO of depth MAX_OUTSTANDING, written at issue.
  - Either way outstanding--.
  - Response-to-instr_valid_o latency is 1 cycle; there is no bypass.
- Decode pop on instr_valid_o && instr_ready_i. A simultaneous push and pop keeps q_count unchanged.
- Redirect (jump_c=1), applied in the same cycle:
  - Queue flushed, so instr_valid_o=0 the next cycle.
  - req_valid_o forced 0 in the jump cycle.
  - fetch_pc ← {jump_addr_i[ADDR_WIDTH-1:2],2'b0}.
  - drop_cnt ← outstanding minus (1 if rsp_valid_i this cycle), i.e. every request still in flight after this edge. A response arriving in the jump cycle is itself discarded.
  - A pop in the jump cycle still completes, since decode saw valid&ready.
  - First request to the target is issued the cycle after jump_c; it may overlap remaining drops and is ordered behind them.
- Back-to-back redirects: each recomputes drop_cnt from current outstanding; the last target wins.
- Idle memory (req_ready_i=0 held): fetch_pc holds. req_valid_o stays asserted and req_addr_o stable until accepted, or until jump_c.
- Reset mid-operation: all state returns to reset values immediately; in-flight responses after reset release are ignored only if the memory is also reset. The system resets both together.
- Counter widths are $clog2(MAX_OUTSTANDING+1) and $clog2(FQ_DEPTH+1).

Decomposition:
- Package if_pkg: typedef fetch_entry_t (struct: pc, instr), localparam NOP_INSTR=32'h00000013 (for decode insertion, not used internally).
- One sub-module, fetch_fifo: generic synchronous FIFO (DEPTH, entry type/width, push/pop/flush, full/empty/count). It is instantiated twice: the fetch queue (FQ_DEPTH) and the PC tag FIFO (MAX_OUTSTANDING).

Test Plan:
- Reset, RESET_VECTOR=32'h100, memory ready with 1-cycle latency, decode ready -> requests 0x100, 0x104, 0x108…; instr_valid_o with pc_o=0x100 two cycles after first issue, then one per cycle.
- Decode ready=0 for 20 cycles -> exactly FQ_DEPTH(4) requests total accepted; req_valid_o=0 afterwards. Release -> 4 pops in order, fetching resumes.
- req_ready_i=0 for 5 cycles -> req_addr_o stable at the same value, no fetch_pc advance, no spurious queue entries.
- 2 outstanding requests (latency 3), jump_c to 32'h2003 -> next request addr 0x2000. Both stale responses dropped; first pc_o after the jump is 0x2000.
- jump_c in the same cycle as rsp_valid_i and instr_valid_o&&instr_ready_i -> pop counted, response discarded, queue empty next cycle, drop_cnt=outstanding-1.
- Assert rst mid-stream with queue full -> asynchronously instr_valid_o=0, req_valid_o=0; after release fetch restarts at RESET_VECTOR.
